// File: rtl/task_8_answer_packer.sv
// task_8_answer_packer: packs 8-bit result bytes into 32-bit answer words.
// A packet closes on a byte flagged last, or when the buffer fills.
// It is then presented to the task manager one word at a time.
// Build option: define TASK_8_PACK_MSB_FIRST_EN to place the first byte of
// each word in bits 31:24 instead of bits 7:0.
module task_8_answer_packer #(
  parameter int DATA_WIDTH_IN  = 8,
  parameter int DATA_WIDTH_OUT = 32,
  parameter int NUM_WORDS      = 8,
  parameter int SIZE_WIDTH     = 12
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [DATA_WIDTH_IN-1:0]  i_data,
  input  logic                      i_data_valid,
  input  logic                      i_data_last,
  output logic                      o_data_ready,
  output logic                      o_drop,
  input  logic                      i_tmanager_ready,
  output logic                      o_tanswer_ready,
  output logic [DATA_WIDTH_OUT-1:0] o_tdata,
  output logic                      o_tanswer_data_last,
  output logic [SIZE_WIDTH-1:0]     o_packet_size_in_bytes
);

  localparam int PTR_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [SIZE_WIDTH-1:0] FULL_BYTES = SIZE_WIDTH'(NUM_WORDS * 4);

  typedef enum logic {
    COLLECT = 1'b0,
    SEND    = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [SIZE_WIDTH-1:0]     byte_cnt_q, byte_cnt_d;
  logic [SIZE_WIDTH-1:0]     size_q, size_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH_OUT-1:0] stage_q, stage_d;
  logic                      drop_q, drop_d;
  logic [DATA_WIDTH_OUT-1:0] mem_q [NUM_WORDS];

  logic                      mem_we;
  logic [DATA_WIDTH_OUT-1:0] mem_wdata;
  logic                      accept;
  logic                      close;
  logic                      handshake;
  logic                      last_word;
  logic [SIZE_WIDTH-1:0]     cnt_inc;
  logic [SIZE_WIDTH-1:0]     words;
  logic [1:0]                lane;
  logic [4:0]                shamt;
  logic [DATA_WIDTH_OUT-1:0] merged;

  // Ready is gated by reset so the upstream stage never sees a stale grant.
  assign o_data_ready = ~i_rst & (state_q == COLLECT);

  // Byte-lane placement, close detection and read-side bookkeeping.
  always_comb begin
    lane = byte_cnt_q[1:0];
`ifdef TASK_8_PACK_MSB_FIRST_EN
    shamt = {~lane, 3'b000};
`else
    shamt = {lane, 3'b000};
`endif
    merged    = stage_q | (DATA_WIDTH_OUT'(i_data) << shamt);
    cnt_inc   = byte_cnt_q + 1'b1;
    words     = (size_q + SIZE_WIDTH'(3)) >> 2;
    accept    = i_data_valid & o_data_ready;
    close     = accept & (i_data_last | (cnt_inc == FULL_BYTES));
    handshake = (state_q == SEND) & i_tmanager_ready;
    last_word = (state_q == SEND) & (SIZE_WIDTH'(rd_ptr_q) == (words - 1'b1));
  end

  // Next-state logic: collect bytes into the staging word, then drain packet.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    size_d     = size_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    stage_d    = stage_q;
    drop_d     = i_data_valid & ~o_data_ready;
    mem_we     = 1'b0;
    mem_wdata  = merged;

    case (state_q)
      COLLECT: begin
        if (accept) begin
          byte_cnt_d = cnt_inc;
          stage_d    = merged;
          // A full word, or the tail of a closing packet, goes to the buffer;
          // the staging word restarts at zero so padding lanes read as zero.
          if ((lane == 2'd3) || close) begin
            mem_we   = 1'b1;
            stage_d  = '0;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
          if (close) begin
            size_d  = cnt_inc;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (handshake) begin
          if (last_word) begin
            state_d    = COLLECT;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            byte_cnt_d = '0;
            size_d     = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Control registers; reset abandons any partial or pending packet.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= COLLECT;
      byte_cnt_q <= '0;
      size_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      stage_q    <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      size_q     <= size_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      stage_q    <= stage_d;
      drop_q     <= drop_d;
    end
  end

  // Word buffer; contents are only observed in SEND so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= mem_wdata;
    end
  end

  assign o_drop                 = drop_q;
  assign o_tanswer_ready        = (state_q == SEND);
  assign o_tdata                = (state_q == SEND) ? mem_q[rd_ptr_q] : '0;
  assign o_tanswer_data_last    = last_word;
  assign o_packet_size_in_bytes = size_q;

endmodule

// File: tb/tb_task_8_answer_packer.sv
// Testbench for task_8_answer_packer: directed packets plus random traffic,
// checked against a packet-level reference model through a word scoreboard.
module tb_task_8_answer_packer;

  localparam int MAX_BYTES = 32;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_data;
  logic        i_data_valid;
  logic        i_data_last;
  logic        o_data_ready;
  logic        o_drop;
  logic        i_tmanager_ready;
  logic        o_tanswer_ready;
  logic [31:0] o_tdata;
  logic        o_tanswer_data_last;
  logic [11:0] o_packet_size_in_bytes;

  task_8_answer_packer dut (
    .i_clk                 (clk),
    .i_rst                 (i_rst),
    .i_data                (i_data),
    .i_data_valid          (i_data_valid),
    .i_data_last           (i_data_last),
    .o_data_ready          (o_data_ready),
    .o_drop                (o_drop),
    .i_tmanager_ready      (i_tmanager_ready),
    .o_tanswer_ready       (o_tanswer_ready),
    .o_tdata               (o_tdata),
    .o_tanswer_data_last   (o_tanswer_data_last),
    .o_packet_size_in_bytes(o_packet_size_in_bytes)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [11:0] s;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] pkt[$];
  bit         pending  = 1'b0;
  bit         cur_send = 1'b0;
  bit         drop_now = 1'b0;
  bit         drop_prev = 1'b0;
  bit         rst_prev = 1'b0;
  int         vectors = 0;
  int         errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %08h want %08h at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: turn a finished packet's byte list into answer words.
  function automatic void close_packet();
    int n;
    int nw;
    n  = pkt.size();
    nw = (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      exp_t e;
      e.d = '0;
      for (int k = 0; k < 4; k++) begin
        if (4 * w + k < n) begin
`ifdef TASK_8_PACK_MSB_FIRST_EN
          e.d[8*(3-k) +: 8] = pkt[4*w+k];
`else
          e.d[8*k +: 8] = pkt[4*w+k];
`endif
        end
      end
      e.l = (w == nw - 1);
      e.s = 12'(n);
      exp_q.push_back(e);
    end
    pkt.delete();
  endfunction

  // One clock of stimulus; the model decides acceptance from packet state.
  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic tr);
    @(posedge clk);
    #1;
    i_data           = d;
    i_data_valid     = v;
    i_data_last      = l;
    i_tmanager_ready = tr;
    cur_send         = pending;
    drop_now         = v && cur_send;
    if (v && !cur_send) begin
      pkt.push_back(d);
      if (l || pkt.size() == MAX_BYTES) begin
        close_packet();
        pending = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n, input logic tr);
    repeat (n) drive(1'b0, 8'h00, 1'b0, tr);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    i_rst            = 1'b1;
    i_data_valid     = 1'b0;
    i_tmanager_ready = 1'b0;
    pending  = 1'b0;
    cur_send = 1'b0;
    drop_now = 1'b0;
    exp_q.delete();
    pkt.delete();
    repeat (n - 1) begin
      @(posedge clk);
      #1;
      drop_now = 1'b0;
    end
    @(posedge clk);
    #1;
    i_rst    = 1'b0;
    cur_send = 1'b0;
    drop_now = 1'b0;
  endtask

  // Monitor: samples mid-cycle and scores against the expected-word queue.
  initial begin
    forever begin
      @(negedge clk);
      if (i_rst) begin
        chk("ready_in_reset", 32'(o_data_ready), 32'd0);
        if (rst_prev) begin
          chk("rst_tanswer_ready", 32'(o_tanswer_ready), 32'd0);
          chk("rst_tdata", o_tdata, 32'd0);
          chk("rst_last", 32'(o_tanswer_data_last), 32'd0);
          chk("rst_size", 32'(o_packet_size_in_bytes), 32'd0);
          chk("rst_drop", 32'(o_drop), 32'd0);
        end
        rst_prev = 1'b1;
      end else begin
        rst_prev = 1'b0;
        chk("drop", 32'(o_drop), 32'(drop_prev));
        chk("data_ready", 32'(o_data_ready), 32'(!cur_send));
        chk("tanswer_ready", 32'(o_tanswer_ready), 32'(cur_send));
        if (cur_send) begin
          if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = exp_q[0];
            chk("tdata", o_tdata, e.d);
            chk("word_last", 32'(o_tanswer_data_last), 32'(e.l));
            chk("size", 32'(o_packet_size_in_bytes), 32'(e.s));
            if (i_tmanager_ready) begin
              void'(exp_q.pop_front());
              if (e.l) pending = 1'b0;
            end
          end
        end else begin
          chk("size_idle", 32'(o_packet_size_in_bytes), 32'd0);
          chk("last_idle", 32'(o_tanswer_data_last), 32'd0);
        end
      end
      drop_prev = drop_now;
    end
  end

  // Stimulus sequence.
  initial begin
    logic [7:0] t1 [4];
    t1 = '{8'h01, 8'h00, 8'h01, 8'h01};
    i_rst            = 1'b1;
    i_data           = '0;
    i_data_valid     = 1'b0;
    i_data_last      = 1'b0;
    i_tmanager_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;

    // Single full word.
    for (int i = 0; i < 4; i++) drive(1'b1, t1[i], 1'(i == 3), 1'b1);
    idle(3, 1'b1);

    // Two words with a padded tail.
    for (int i = 1; i <= 6; i++) drive(1'b1, 8'(i), 1'(i == 6), 1'b1);
    idle(4, 1'b1);

    // Task manager stalls five cycles before draining.
    for (int i = 1; i <= 6; i++) drive(1'b1, 8'(8'h20 + i), 1'(i == 6), 1'b0);
    idle(5, 1'b0);
    idle(4, 1'b1);

    // Auto-close on a full buffer; the next byte is dropped.
    for (int i = 0; i < MAX_BYTES; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    drive(1'b1, 8'hEE, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(10, 1'b1);

    // Reset in the middle of SEND, then a short packet.
    for (int i = 0; i < 8; i++) drive(1'b1, 8'($urandom), 1'(i == 7), 1'b0);
    idle(2, 1'b0);
    do_reset(2);
    drive(1'b1, 8'h0A, 1'b0, 1'b1);
    drive(1'b1, 8'h0B, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Random traffic with stalls, drops and auto-closes.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom),
            1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 9) < 7));
    end

    for (int i = 0; i < 200 && pending; i++) drive(1'b0, 8'h00, 1'b0, 1'b1);
    idle(2, 1'b1);
    chk("drain_pending", 32'(pending), 32'd0);
    chk("leftover_words", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/task_8_answer_packer.md
# task_8_answer_packer

Output-side packing stage of the task 8 datapath; sits directly downstream of the neuron wrapper. It accepts 8-bit result bytes one per cycle, packs them into 32-bit answer words in a small buffer, and closes a packet when the last result arrives or the buffer fills. It then presents the packet to the task manager word-by-word, with byte count and last-word marking.

## Interface
- DATA_WIDTH_IN, 8, result byte width (fixed 8; other values unsupported)
- DATA_WIDTH_OUT, 32, answer word width (fixed 32)
- NUM_WORDS, 8, buffer depth in answer words; NUM_WORDS*4 must be < 4096
- SIZE_WIDTH, 12, width of packet byte count

- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_data  in  8  result byte from neuron stage
- i_data_valid  in  1  i_data valid this cycle
- i_data_last  in  1  qualifies i_data as final result of packet (only sampled with i_data_valid)
- o_data_ready  out  1  packer can accept a byte this cycle
- o_drop  out  1  one-cycle pulse: valid byte arrived while o_data_ready=0 and was discarded
- i_tmanager_ready  in  1  task manager accepts current word
- o_tanswer_ready  out  1  packet available; o_tdata valid
- o_tdata  out  32  current answer word
- o_tanswer_data_last  out  1  current word is final word of packet
- o_packet_size_in_bytes  out  SIZE_WIDTH  byte count of presented packet

## Operation
- States: COLLECT, SEND. Reset -> COLLECT.
- COLLECT: o_data_ready=1. Accepted byte written into lane byte_cnt[1:0] of staging register; lane 0 = bits 7:0 (little-endian). byte_cnt increments by 1.
- Staging word is committed to mem[wr_ptr] when lane 3 is written or when the packet closes. Unwritten lanes of a partial word are zero.
- Packet closes on either event:
  - an accepted byte with i_data_last=1;
  - byte_cnt reaching NUM_WORDS*4 (auto-close).
- On close: the packet size register takes the final byte_cnt; number of words = ceil(size/4); state -> SEND.
- SEND: o_data_ready=0; o_tanswer_ready=1; o_tdata = mem[rd_ptr] (combinational read of the register array). A handshake (o_tanswer_ready & i_tmanager_ready) advances rd_ptr.
- o_tanswer_data_last = 1 while rd_ptr == words-1.
- Handshake on the last word: state -> COLLECT; rd_ptr, wr_ptr, byte_cnt and the size register are cleared to 0.
- A byte valid in SEND is discarded and o_drop pulses on the following cycle. Bytes are never buffered across packets.
- Reset at any point discards any partial or pending packet.
- Reset values: o_data_ready=0 during reset, 1 on the first cycle after reset. o_drop, o_tanswer_ready, o_tdata, o_tanswer_data_last and o_packet_size_in_bytes are all 0.

## Timing
- Byte accepted at edge N with close condition: o_tanswer_ready=1 from cycle N+1. The word containing that byte is readable at that point.
- o_tdata, o_tanswer_data_last and o_packet_size_in_bytes are stable throughout SEND while i_tmanager_ready=0. Each changes only after a handshake.
- Throughput in SEND is one word per cycle with i_tmanager_ready held high.
- o_data_ready returns to 1 on the cycle after the last-word handshake. Minimum gap between packets is 1 cycle.
- Packet size is zero outside SEND.

## Configuration
- TASK_8_PACK_MSB_FIRST_EN
  - Defined: lane 0 = bits 31:24, so the first byte occupies the MSB. Zero padding goes in the low lanes.
  - Undefined: little-endian lane order as in Operation.
  - Nothing else is affected.

## Test plan
- Bytes 01,00,01,01, with last on the 4th -> one word 0x01010001, size 4, last=1, o_tanswer_ready one cycle after the 4th byte.
- Bytes 01..06, with last on 06 -> words 0x04030201 then 0x00000605, size 6, last only on the second word.
- Packet ready, i_tmanager_ready held 0 for 5 cycles then 1 -> word 0 held stable for 5 cycles, then 2 consecutive words.
- 32 bytes with no last -> auto-close, size 32, 8 words. A 33rd valid byte in SEND -> o_drop pulse, not packed.
- i_rst asserted mid-SEND -> all outputs 0 next cycle. The following 2-byte packet 0A,0B reads 0x00000B0A, size 2.
- With TASK_8_PACK_MSB_FIRST_EN defined, bytes 01,00,01,01 -> 0x01000101; bytes 0A,0B (last) -> 0x0A0B0000.
